// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
`timescale 1ns/1ps
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_STEP       = 4;
  // Wide enough to be truncated to any address width up to 64 bits.
  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and hands
// {pc, insn} to decode; redirects squash the presented word and stale responses.
`timescale 1ns/1ps
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
);

  localparam logic [AWIDTH-1:0] ALIGN_MASK = AWIDTH'(PC_ALIGN_MASK);
  localparam logic [AWIDTH-1:0] STEP       = AWIDTH'(PC_STEP);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [AWIDTH-1:0] pc_q;
  logic              req_fire;

  always_comb begin
    state_d          = state_q;
    imem_req_valid_o = (state_q == S_REQ) && !rst;
    imem_req_addr_o  = pc_q;
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    case (state_q)
      // A redirect in the accepting cycle still leaves one response to swallow.
      S_REQ:  if (req_fire) state_d = redirect_i ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (redirect_i)            state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
        else if (imem_rsp_valid_i) state_d = S_HOLD;
      end
      S_HOLD: if (redirect_i || insn_ready_i) state_d = S_REQ;
      // Further redirects here only retarget pc_q; leave once the stale word is gone.
      S_DROP: if (imem_rsp_valid_i) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= BASEADDR;
      insn_valid_o <= 1'b0;
      pc_o         <= BASEADDR;
      insn_o       <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        pc_q         <= redirect_pc_i & ALIGN_MASK;
        insn_valid_o <= 1'b0;
      end else begin
        case (state_q)
          S_WAIT: if (imem_rsp_valid_i) begin
            insn_o       <= imem_rsp_data_i;
            pc_o         <= pc_q;
            insn_valid_o <= 1'b1;
            pc_q         <= pc_q + STEP;
          end
          S_HOLD: if (insn_ready_i) insn_valid_o <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a memory model answers requests, a reference
// PC stream predicts what decode must see, and a monitor checks every handoff.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] pc_o;
  logic [31:0] insn_o;

  fetch_ctrl #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .insn_valid_o     (insn_valid),
    .insn_ready_i     (insn_ready),
    .pc_o             (pc_o),
    .insn_o           (insn_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] exp_pc;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_deliv = 0;
  int          cyc = 0;

  // Memory behaviour knobs, written by the stimulus process.
  int ready_mode = 0;   // 0 always ready, 1 random, 2 never
  int lat_lo = 0;
  int lat_hi = 0;
  bit spur_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, req);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: got no event within cycle budget, required one", name);
  endtask

  // Instruction memory: one response per accepted request, latency lat_lo..lat_hi.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_lat;
    pend = 1'b0; pend_addr = '0; pend_lat = 0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (rst) pend = 1'b0;
      else if (imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        pend_lat  = $urandom_range(lat_hi, lat_lo);
      end
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      if (rst) imem_req_ready = 1'b0;
      else begin
        if (pend) begin
          if (pend_lat == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pend           = 1'b0;
          end else pend_lat--;
        end else if (spur_en && $urandom_range(7, 0) == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = $urandom;
        end
        case (ready_mode)
          0:       imem_req_ready = 1'b1;
          1:       imem_req_ready = ($urandom_range(3, 0) != 0);
          default: imem_req_ready = 1'b0;
        endcase
      end
    end
  end

  // Monitor + reference model: decode sees the sequential stream from the last
  // redirect target (or BASE after reset); anything fetched before is discarded.
  initial begin
    exp_t e;
    exp_pc = BASE;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        exp_pc = BASE;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          req_addr_q.push_back(imem_req_addr);
          req_cyc_q.push_back(cyc);
        end
        if (redirect) begin
          exp_q.delete();
          exp_pc = redirect_pc & ~32'h3;
        end else begin
          if (insn_valid && insn_ready) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL dec_unexpected: got pc %h insn %h, required no instruction", pc_o, insn_o);
            end else begin
              e = exp_q.pop_front();
              check("dec_pc", pc_o, e.pc);
              check("dec_insn", insn_o, e.insn);
              n_deliv++;
            end
          end
          if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            e.pc   = exp_pc;
            e.insn = mem_word(exp_pc);
            exp_q.push_back(e);
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic drive();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string name, input logic [31:0] req);
    int n0;
    int i;
    n0 = req_addr_q.size();
    i  = 0;
    while (req_addr_q.size() <= n0 && i < 100) begin step(); i++; end
    if (req_addr_q.size() <= n0) timeout(name);
    else check(name, req_addr_q[n0], req);
  endtask

  task automatic wait_valid(input string name);
    int i;
    i = 0;
    while (!insn_valid && i < 100) begin step(); i++; end
    if (!insn_valid) timeout(name);
  endtask

  initial begin
    logic [31:0] pc_h;
    logic [31:0] insn_h;
    int          d0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; insn_ready = 1'b1;
    ready_mode = 2;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_insn_valid", {31'd0, insn_valid}, 32'd0);
    check("rst_pc_o", pc_o, BASE);
    check("rst_insn_o", insn_o, 32'd0);
    @(negedge clk); #2 rst = 1'b0;

    // Memory stalls: request must hold its address.
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_req_addr", imem_req_addr, BASE);
    end
    ready_mode = 0;

    // Zero-wait stream: three requests, 3-cycle spacing.
    begin
      int i;
      i = 0;
      while (req_cyc_q.size() < 3 && i < 60) begin step(); i++; end
    end
    if (req_cyc_q.size() < 3) timeout("stream_reqs");
    else begin
      check("stream_addr0", req_addr_q[0], BASE);
      check("stream_addr1", req_addr_q[1], BASE + 32'd4);
      check("stream_addr2", req_addr_q[2], BASE + 32'd8);
      check("stream_gap01", 32'(req_cyc_q[1] - req_cyc_q[0]), 32'd3);
      check("stream_gap12", 32'(req_cyc_q[2] - req_cyc_q[1]), 32'd3);
    end

    // Decode backpressure.
    drive(); insn_ready = 1'b0;
    wait_valid("bp_valid");
    pc_h = pc_o; insn_h = insn_o;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_insn_valid", {31'd0, insn_valid}, 32'd1);
      check("bp_pc_hold", pc_o, pc_h);
      check("bp_insn_hold", insn_o, insn_h);
      check("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    drive(); insn_ready = 1'b1;

    // Redirect while waiting on a slow response.
    lat_lo = 3; lat_hi = 3;
    wait_req("wait_prior_req", req_addr_q.size() > 0 ? exp_pc : exp_pc);
    drive(); redirect = 1'b1; redirect_pc = 32'h0100_0040;
    drive(); redirect = 1'b0;
    wait_req("redir_wait_addr", 32'h0100_0040);
    wait_valid("redir_wait_deliv");
    check("redir_wait_pc", pc_o, 32'h0100_0040);

    // Redirect in the same cycle as the response.
    lat_lo = 0; lat_hi = 0;
    wait_req("wait_prior_req2", exp_pc);
    drive(); redirect = 1'b1; redirect_pc = 32'h0100_0080;
    drive(); redirect = 1'b0;
    wait_req("redir_rsp_addr", 32'h0100_0080);

    // Misaligned target and address wrap, redirected from HOLD.
    drive(); insn_ready = 1'b0;
    wait_valid("align_hold");
    drive(); redirect = 1'b1; redirect_pc = 32'h0100_0103;
    drive(); redirect = 1'b0; insn_ready = 1'b1;
    wait_req("align_addr", 32'h0100_0100);
    drive(); insn_ready = 1'b0;
    wait_valid("wrap_hold");
    drive(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    drive(); redirect = 1'b0; insn_ready = 1'b1;
    wait_req("wrap_top_addr", 32'hFFFF_FFFC);
    wait_req("wrap_zero_addr", 32'h0000_0000);

    // Asynchronous reset while holding an instruction.
    drive(); insn_ready = 1'b0;
    wait_valid("arst_hold");
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("arst_insn_valid", {31'd0, insn_valid}, 32'd0);
    check("arst_pc_o", pc_o, BASE);
    check("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0; insn_ready = 1'b1;
    wait_req("arst_restart_addr", BASE);

    // Randomized traffic.
    ready_mode = 1; lat_lo = 0; lat_hi = 3; spur_en = 1'b1;
    d0 = n_deliv;
    for (int i = 0; i < 1500; i++) begin
      drive();
      insn_ready  = ($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(19, 0) == 0);
      redirect_pc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                : $urandom;
    end
    drive(); redirect = 1'b0; insn_ready = 1'b1;
    repeat (20) step();
    check("rand_progress", {31'd0, (n_deliv - d0) >= 50}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
